pipe_ctrl_unit: RTL
===================

Name: pipe_ctrl_unit

Overview:
Next-generation MIPS pipeline control unit. It decodes the ID-stage opcode into WB/M/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards, inserts bubbles, and squashes wrong-path instructions on jumps and taken branches. It adds bne/addi decode, proper jump handling, and saturating stall/flush performance counters.

Parameters:
INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-6], rs [25:21], rt [20:16]
EN_BNE, 1, decode opcode 6'h05 (bne); when 0 it is treated as illegal
EN_ADDI, 1, decode opcode 6'h08 (addi); when 0 it is treated as illegal
CNT_W, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
id_instr  in  INSTR_W  instruction in IF/ID
mem_branch_taken  in  1  branch resolved taken in MEM (datapath: M.Branch & zero/!zero)
id_ex_wb  out  2  {RegWrite, MemToReg}
id_ex_m  out  4  {BranchNe, Branch, MemRead, MemWrite}
id_ex_ex  out  4  {RegDst, ALUOp[1:0], ALUSrc}
ex_mem_wb  out  2  WB bundle in EX/MEM
ex_mem_m  out  4  M bundle in EX/MEM
mem_wb_wb  out  2  WB bundle in MEM/WB
stall  out  1  hold PC and IF/ID (combinational)
if_flush  out  1  zero IF/ID on next edge (combinational)
illegal_op  out  1  registered one-cycle pulse: undecodable opcode entered ID/EX
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of cycles with if_flush=1

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. On reset all control registers, illegal_op and both counters are 0.
- Decode (combinational). Each entry gives WB / M / EX:
  - R-type 00: 10 / 0000 / 1100
  - lw 23: 11 / 0010 / 0001
  - sw 2b: 00 / 0001 / 0001
  - beq 04: 00 / 0100 / 0010
  - bne 05: 00 / 1100 / 0010
  - addi 08: 10 / 0000 / 0001
  - j 02: all bundles zero, jump=1
  - anything else: all bundles zero, illegal=1
- Load-use hazard (hz), evaluated on registered ID/EX state: hz = id_ex MemRead & id_ex_rt!=0 & (id_ex_rt==id_rs | (id_ex_rt==id_rt & ID op in {R, sw, beq, bne})).
  - j, lw, addi never compare rt.
  - id_ex_rt and id_ex MemRead are tracked internally.
- Each edge, priority highest first:
  1. mem_branch_taken=1: if_flush=1, stall=0. ID/EX and EX/MEM bundles load zero. MEM/WB loads the EX/MEM WB bundle normally (the branch itself writes nothing).
  2. hz=1: stall=1, if_flush=0. ID/EX loads zero (bubble), id_ex_rt=0. EX/MEM and MEM/WB advance.
  3. Otherwise: ID/EX loads the decoded bundle and id_rt; EX/MEM and MEM/WB advance. if_flush = ID jump.
- Jump costs exactly one bubble: the IF instruction is squashed, and the zero bundle travels down the pipe.
- illegal_op is the registered decode-illegal flag. It is suppressed when that ID slot is bubbled or flushed.
- Counters increment by 1 on cycles with stall=1 or if_flush=1 respectively. They hold at 2^CNT_W-1 and never wrap.
- Reset mid-operation clears everything on that edge. It overrides flush and stall; stall and if_flush read 0 while rst=1.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - ALUOp encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - bundle widths WB_W=2, M_W=4, EX_W=4
  - packed structs for the three bundles
- One combinational sub-module, ctrl_decode (opcode -> bundles, jump, illegal, uses_rt). The hazard logic, pipeline registers and counters live in the top.

Test Plan:
- Reset, then R-type (op 00): id_ex_ex=1100 and id_ex_wb=10 after 1 edge; mem_wb_wb=10 after 3 edges; stall=0, if_flush=0 throughout.
- lw $rt=5, then add using rs=5: stall=1 for exactly one cycle; bubble gives id_ex all zero; stall_cnt=1; add enters ID/EX on the following edge.
- lw rt=0, then consumer of $0: no stall. lw rt=5, then addi with rt=5 as destination (rs≠5): no stall.
- beq in pipe, mem_branch_taken=1 while a lw hazard is also present: if_flush=1, stall=0; id_ex and ex_mem bundles zero next cycle; flush_cnt=1.
- j (op 02) in ID: if_flush=1 for one cycle; id_ex bundles all zero. Opcode 3f: illegal_op pulses 1 cycle; EN_BNE=0 makes op 05 illegal.
- Force stall for 2^CNT_W+3 cycles with CNT_W=4: stall_cnt holds at 15. Assert rst mid-stream: all outputs 0 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcodes, ALUOp encodings and control-bundle types for the MIPS
// pipeline control unit.
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_W = 2;
  localparam int M_W  = 4;
  localparam int EX_W = 4;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_t;

  typedef struct packed {
    logic branch_ne;
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_t;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_t;

  typedef struct packed {
    wb_t  wb;
    m_t   m;
    ex_t  ex;
    logic jump;
    logic illegal;
    logic uses_rt;
  } dec_t;
endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage inputs and pipeline-control outputs of pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] id_instr;
  logic               mem_branch_taken;
  logic [1:0]         id_ex_wb;
  logic [3:0]         id_ex_m;
  logic [3:0]         id_ex_ex;
  logic [1:0]         ex_mem_wb;
  logic [3:0]         ex_mem_m;
  logic [1:0]         mem_wb_wb;
  logic               stall;
  logic               if_flush;
  logic               illegal_op;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output id_instr, mem_branch_taken,
    input  id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb,
    input  stall, if_flush, illegal_op, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_instr, mem_branch_taken,
    output id_ex_wb, id_ex_m, id_ex_ex, ex_mem_wb, ex_mem_m, mem_wb_wb,
    output stall, if_flush, illegal_op, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Opcode decoder: control bundles plus jump/illegal flags and whether the
// instruction reads rt as a source (needed by the load-use check).
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic [5:0] op,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    unique case (op)
      OP_RTYPE: begin
        dec.wb      = '{reg_write: 1'b1, mem_to_reg: 1'b0};
        dec.ex      = '{reg_dst: 1'b1, alu_op: ALUOP_FUNCT, alu_src: 1'b0};
        dec.uses_rt = 1'b1;
      end
      OP_LW: begin
        dec.wb = '{reg_write: 1'b1, mem_to_reg: 1'b1};
        dec.m.mem_read = 1'b1;
        dec.ex = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
      end
      OP_SW: begin
        dec.m.mem_write = 1'b1;
        dec.ex      = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
        dec.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.m.branch = 1'b1;
        dec.ex       = '{reg_dst: 1'b0, alu_op: ALUOP_SUB, alu_src: 1'b0};
        dec.uses_rt  = 1'b1;
      end
      OP_BNE: begin
        // Disabled bne falls back to the illegal path with all bundles zero.
        if (EN_BNE) begin
          dec.m.branch_ne = 1'b1;
          dec.m.branch    = 1'b1;
          dec.ex          = '{reg_dst: 1'b0, alu_op: ALUOP_SUB, alu_src: 1'b0};
          dec.uses_rt     = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_ADDI: begin
        if (EN_ADDI) begin
          dec.wb.reg_write = 1'b1;
          dec.ex = '{reg_dst: 1'b0, alu_op: ALUOP_ADD, alu_src: 1'b1};
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_J:    dec.jump    = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// MIPS pipeline control: ID decode, ID/EX..MEM/WB control registers,
// load-use stall, branch/jump squash and saturating stall/flush counters.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter bit EN_BNE  = 1'b1,
  parameter bit EN_ADDI = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_ctrl_unit_if.slave    bus
);
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  dec_t       dec;

  assign id_op = bus.id_instr[INSTR_W-1 -: 6];
  assign id_rs = bus.id_instr[25:21];
  assign id_rt = bus.id_instr[20:16];

  logic unused_imm;
  assign unused_imm = ^bus.id_instr[15:0];

  ctrl_decode #(.EN_BNE(EN_BNE), .EN_ADDI(EN_ADDI)) u_dec (
    .op  (id_op),
    .dec (dec)
  );

  wb_t              id_ex_wb_q, ex_mem_wb_q, mem_wb_wb_q;
  m_t               id_ex_m_q, ex_mem_m_q;
  ex_t              id_ex_ex_q;
  logic [4:0]       id_ex_rt_q;
  logic             illegal_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             hz, taken, stall_c, flush_c;

  // Load-use: the load in ID/EX writes a register the ID instruction reads.
  assign hz = id_ex_m_q.mem_read && (id_ex_rt_q != 5'd0) &&
              ((id_ex_rt_q == id_rs) || ((id_ex_rt_q == id_rt) && dec.uses_rt));
  assign taken   = bus.mem_branch_taken;
  assign stall_c = !rst && !taken && hz;
  assign flush_c = !rst && (taken || (!hz && dec.jump));

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_wb_q  <= '0;
      id_ex_m_q   <= '0;
      id_ex_ex_q  <= '0;
      id_ex_rt_q  <= '0;
      ex_mem_wb_q <= '0;
      ex_mem_m_q  <= '0;
      mem_wb_wb_q <= '0;
      illegal_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      mem_wb_wb_q <= ex_mem_wb_q;
      if (taken || hz) begin
        id_ex_wb_q <= '0;
        id_ex_m_q  <= '0;
        id_ex_ex_q <= '0;
        id_ex_rt_q <= '0;
        illegal_q  <= 1'b0;
      end else begin
        id_ex_wb_q <= dec.wb;
        id_ex_m_q  <= dec.m;
        id_ex_ex_q <= dec.ex;
        id_ex_rt_q <= id_rt;
        illegal_q  <= dec.illegal;
      end
      // A taken branch squashes everything younger than itself, including EX.
      if (taken) begin
        ex_mem_wb_q <= '0;
        ex_mem_m_q  <= '0;
      end else begin
        ex_mem_wb_q <= id_ex_wb_q;
        ex_mem_m_q  <= id_ex_m_q;
      end
      if (stall_c && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_c && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.id_ex_wb   = id_ex_wb_q;
  assign bus.id_ex_m    = id_ex_m_q;
  assign bus.id_ex_ex   = id_ex_ex_q;
  assign bus.ex_mem_wb  = ex_mem_wb_q;
  assign bus.ex_mem_m   = ex_mem_m_q;
  assign bus.mem_wb_wb  = mem_wb_wb_q;
  assign bus.stall      = stall_c;
  assign bus.if_flush   = flush_c;
  assign bus.illegal_op = illegal_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
endmodule
